per2axi_req_channel: RTL and testbench

PER2AXI_REQ_CHANNEL -- requirements
Module: per2axi_req_channel

---
 rtl/per2axi_req_channel.sv | 110 +++++++++++
 tb/tb_per2axi_req_channel.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/per2axi_req_channel.sv
// per2axi_req_channel: turns granted peripheral requests into single-beat AXI AR or AW+W transfers
// and tracks per-requester outstanding transactions so that each ID has at most one in flight.
module per2axi_req_channel #(
   parameter int PER_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        per_slave_req_i,
   input  logic [31:0]                 per_slave_add_i,
   input  logic                        per_slave_we_ni,
   input  logic [31:0]                 per_slave_wdata_i,
   input  logic [3:0]                  per_slave_be_i,
   input  logic [PER_ID_WIDTH-1:0]     per_slave_id_i,
   input  logic [5:0]                  per_slave_atop_i,
   output logic                        per_slave_gnt_o,
   input  logic                        rsp_valid_i,
   input  logic [PER_ID_WIDTH-1:0]     rsp_id_i,
   output logic                        axi_master_aw_valid_o,
   input  logic                        axi_master_aw_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_master_aw_addr_o,
   output logic [5:0]                  axi_master_aw_atop_o,
   output logic [AXI_ID_WIDTH-1:0]     axi_master_aw_id_o,
   output logic                        axi_master_w_valid_o,
   input  logic                        axi_master_w_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]   axi_master_w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_master_w_strb_o,
   output logic                        axi_master_ar_valid_o,
   input  logic                        axi_master_ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_master_ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0]     axi_master_ar_id_o,
   output logic                        trans_req_o,
   output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   trans_add_o,
   output logic                        atop_req_o,
   output logic [AXI_ID_WIDTH-1:0]     atop_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   atop_add_o
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam int STRB_W = AXI_DATA_WIDTH/8;

   logic [1:0]                state_q;
   logic [PER_ID_WIDTH-1:0]   busy_q;
   logic [AXI_ID_WIDTH-1:0]   id_bin;
   logic [AXI_ADDR_WIDTH-1:0] add_aligned;
   logic                      is_atop, aw_done, w_done;

   always_comb begin
      id_bin = '0;
      for (int i = 0; i < PER_ID_WIDTH; i++)
         if (per_slave_id_i[i]) id_bin = AXI_ID_WIDTH'(i);
   end

   // gating with rst_ni keeps grant and notices quiet while reset is held
   assign per_slave_gnt_o = rst_ni & per_slave_req_i & (state_q == IDLE) & ~|(busy_q & per_slave_id_i);
   assign add_aligned     = AXI_ADDR_WIDTH'({per_slave_add_i[31:3], 3'b000});
   assign is_atop         = ~per_slave_we_ni & per_slave_atop_i[5];
   assign trans_req_o     = per_slave_gnt_o & ~is_atop;
   assign atop_req_o      = per_slave_gnt_o & is_atop;
   assign trans_id_o      = id_bin;
   assign atop_id_o       = id_bin;
   assign trans_add_o     = AXI_ADDR_WIDTH'(per_slave_add_i);
   assign atop_add_o      = AXI_ADDR_WIDTH'(per_slave_add_i);
   assign aw_done         = ~axi_master_aw_valid_o | axi_master_aw_ready_i;
   assign w_done          = ~axi_master_w_valid_o | axi_master_w_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q               <= IDLE;
         busy_q                <= '0;
         axi_master_aw_valid_o <= 1'b0;
         axi_master_w_valid_o  <= 1'b0;
         axi_master_ar_valid_o <= 1'b0;
         axi_master_aw_addr_o  <= '0;
         axi_master_aw_atop_o  <= '0;
         axi_master_aw_id_o    <= '0;
         axi_master_w_data_o   <= '0;
         axi_master_w_strb_o   <= '0;
         axi_master_ar_addr_o  <= '0;
         axi_master_ar_id_o    <= '0;
      end else begin
         busy_q <= (busy_q & ~(rsp_valid_i ? rsp_id_i : '0)) | (per_slave_gnt_o ? per_slave_id_i : '0);
         if (per_slave_gnt_o && per_slave_we_ni) begin
            axi_master_ar_addr_o  <= add_aligned;
            axi_master_ar_id_o    <= id_bin;
            axi_master_ar_valid_o <= 1'b1;
            state_q               <= READ;
         end
         if (per_slave_gnt_o && !per_slave_we_ni) begin
            axi_master_aw_addr_o  <= add_aligned;
            axi_master_aw_atop_o  <= per_slave_atop_i;
            axi_master_aw_id_o    <= id_bin;
            axi_master_w_data_o   <= AXI_DATA_WIDTH'({per_slave_wdata_i, per_slave_wdata_i});
            axi_master_w_strb_o   <= STRB_W'(per_slave_add_i[2] ? {per_slave_be_i, 4'b0} : {4'b0, per_slave_be_i});
            axi_master_aw_valid_o <= 1'b1;
            axi_master_w_valid_o  <= 1'b1;
            state_q               <= WRITE;
         end
         if (axi_master_ar_valid_o && axi_master_ar_ready_i) axi_master_ar_valid_o <= 1'b0;
         if (axi_master_aw_valid_o && axi_master_aw_ready_i) axi_master_aw_valid_o <= 1'b0;
         if (axi_master_w_valid_o && axi_master_w_ready_i) axi_master_w_valid_o <= 1'b0;
         if (state_q == READ && axi_master_ar_valid_o && axi_master_ar_ready_i) state_q <= IDLE;
         if (state_q == WRITE && aw_done && w_done) state_q <= IDLE;
      end
   end
endmodule

// File: tb/tb_per2axi_req_channel.sv
// tb_per2axi_req_channel: directed checks of grant, AXI payloads, notices, busy tracking and reset.
module tb_per2axi_req_channel;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        req = 1'b0, we_n = 1'b1, rsp_valid = 1'b0;
   logic [31:0] add = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic [4:0]  id = '0, rsp_id = '0;
   logic [5:0]  atop = '0;
   logic        gnt, aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0, ar_valid, ar_ready = 1'b0;
   logic [31:0] aw_addr, ar_addr, trans_add, atop_add;
   logic [5:0]  aw_atop;
   logic [2:0]  aw_id, ar_id, trans_id, atop_id;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        trans_req, atop_req;
   int          checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   per2axi_req_channel dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_ni(we_n),
      .per_slave_wdata_i(wdata), .per_slave_be_i(be), .per_slave_id_i(id),
      .per_slave_atop_i(atop), .per_slave_gnt_o(gnt),
      .rsp_valid_i(rsp_valid), .rsp_id_i(rsp_id),
      .axi_master_aw_valid_o(aw_valid), .axi_master_aw_ready_i(aw_ready),
      .axi_master_aw_addr_o(aw_addr), .axi_master_aw_atop_o(aw_atop), .axi_master_aw_id_o(aw_id),
      .axi_master_w_valid_o(w_valid), .axi_master_w_ready_i(w_ready),
      .axi_master_w_data_o(w_data), .axi_master_w_strb_o(w_strb),
      .axi_master_ar_valid_o(ar_valid), .axi_master_ar_ready_i(ar_ready),
      .axi_master_ar_addr_o(ar_addr), .axi_master_ar_id_o(ar_id),
      .trans_req_o(trans_req), .trans_id_o(trans_id), .trans_add_o(trans_add),
      .atop_req_o(atop_req), .atop_id_o(atop_id), .atop_add_o(atop_add)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_aw_valid", aw_valid, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_trans_req", trans_req, 0);
      @(negedge clk_i) rst_ni = 1'b1;
      // read, id 2
      @(negedge clk_i) begin req = 1; id = 5'b00100; add = 32'h104; we_n = 1; end
      #1;
      chk("rd_gnt", gnt, 1);
      chk("rd_trans_req", trans_req, 1);
      chk("rd_trans_id", trans_id, 2);
      chk("rd_trans_add", trans_add, 32'h104);
      chk("rd_atop_req", atop_req, 0);
      @(negedge clk_i) req = 0;
      #1;
      chk("rd_ar_valid", ar_valid, 1);
      chk("rd_ar_addr", ar_addr, 32'h100);
      chk("rd_ar_id", ar_id, 2);
      chk("rd_aw_valid", aw_valid, 0);
      @(negedge clk_i) ar_ready = 1;
      #1 chk("rd_ar_hold", ar_valid, 1);
      // same id while busy
      @(negedge clk_i) begin ar_ready = 0; req = 1; add = 32'h108; end
      #1;
      chk("rd_ar_drop", ar_valid, 0);
      chk("busy_gnt", gnt, 0);
      @(negedge clk_i) begin rsp_valid = 1; rsp_id = 5'b00100; end
      #1 chk("busy_rsp_cycle_gnt", gnt, 0);
      @(negedge clk_i) rsp_valid = 0;
      #1;
      chk("busy_after_rsp_gnt", gnt, 1);
      chk("busy_after_rsp_add", trans_add, 32'h108);
      @(negedge clk_i) req = 0;
      #1 chk("rd2_ar_addr", ar_addr, 32'h108);
      @(negedge clk_i) ar_ready = 1;
      @(negedge clk_i) begin ar_ready = 0; rsp_valid = 1; rsp_id = 5'b00100; end
      @(negedge clk_i) rsp_valid = 0;
      // write, W ready before AW (cycle 0 = grant)
      @(negedge clk_i) begin req = 1; id = 5'b00010; we_n = 0; add = 32'h20C; be = 4'hF; wdata = 32'hDEADBEEF; atop = 0; end
      #1;
      chk("wr_gnt", gnt, 1);
      chk("wr_trans_req", trans_req, 1);
      chk("wr_trans_id", trans_id, 1);
      chk("wr_atop_req", atop_req, 0);
      @(negedge clk_i) begin req = 0; w_ready = 1; end
      #1;
      chk("wr_aw_valid", aw_valid, 1);
      chk("wr_w_valid", w_valid, 1);
      chk("wr_aw_addr", aw_addr, 32'h208);
      chk("wr_w_strb", w_strb, 8'hF0);
      chk("wr_w_data", w_data, 64'hDEADBEEF_DEADBEEF);
      chk("wr_aw_id", aw_id, 1);
      chk("wr_aw_atop", aw_atop, 0);
      @(negedge clk_i) begin w_ready = 0; req = 1; id = 5'b01000; we_n = 1; add = 32'h40; end
      #1;
      chk("wr_w_done", w_valid, 0);
      chk("wr_aw_pending", aw_valid, 1);
      chk("not_idle_gnt", gnt, 0);
      @(negedge clk_i) begin req = 0; aw_ready = 1; end
      #1;
      chk("wr_aw_hold", aw_valid, 1);
      chk("not_idle_no_ar", ar_valid, 0);
      @(negedge clk_i) begin aw_ready = 0; req = 1; end
      #1;
      chk("wr_aw_done", aw_valid, 0);
      chk("wr_idle_c4_gnt", gnt, 1);
      @(negedge clk_i) begin req = 0; ar_ready = 1; end
      #1;
      chk("rd3_ar_id", ar_id, 3);
      chk("rd3_ar_addr", ar_addr, 32'h40);
      @(negedge clk_i) begin ar_ready = 0; rsp_valid = 1; rsp_id = 5'b01010; end
      @(negedge clk_i) rsp_valid = 0;
      // atomic, both handshakes in the same cycle
      @(negedge clk_i) begin req = 1; id = 5'b10000; we_n = 0; add = 32'h31; be = 4'h3; wdata = 32'h12345678; atop = 6'h20; end
      #1;
      chk("at_gnt", gnt, 1);
      chk("at_atop_req", atop_req, 1);
      chk("at_trans_req", trans_req, 0);
      chk("at_atop_id", atop_id, 4);
      chk("at_atop_add", atop_add, 32'h31);
      @(negedge clk_i) begin req = 0; atop = 0; aw_ready = 1; w_ready = 1; end
      #1;
      chk("at_aw_atop", aw_atop, 6'h20);
      chk("at_w_strb", w_strb, 8'h03);
      chk("at_aw_addr", aw_addr, 32'h30);
      chk("at_w_data", w_data, 64'h12345678_12345678);
      @(negedge clk_i) begin aw_ready = 0; w_ready = 0; req = 1; we_n = 1; add = 32'h8; end
      #1;
      chk("at_aw_done", aw_valid, 0);
      chk("at_w_done", w_valid, 0);
      chk("at_busy_gnt", gnt, 0);
      @(negedge clk_i) begin rsp_valid = 1; rsp_id = 5'b10000; end
      #1 chk("at_rsp_cycle_gnt", gnt, 0);
      @(negedge clk_i) rsp_valid = 0;
      #1 chk("at_after_rsp_gnt", gnt, 1);
      @(negedge clk_i) begin req = 0; ar_ready = 1; end
      @(negedge clk_i) ar_ready = 0;
      // reset in the middle of a write, id 4 still busy
      @(negedge clk_i) begin req = 1; id = 5'b00001; we_n = 0; add = 32'h0; be = 4'h1; wdata = 32'hA5A5A5A5; end
      #1 chk("rs_wr_gnt", gnt, 1);
      @(negedge clk_i) req = 0;
      #1 chk("rs_aw_valid_pre", aw_valid, 1);
      #2 rst_ni = 0;
      #1;
      chk("rs_aw_valid", aw_valid, 0);
      chk("rs_w_valid", w_valid, 0);
      chk("rs_ar_valid", ar_valid, 0);
      chk("rs_w_data", w_data, 0);
      chk("rs_aw_addr", aw_addr, 0);
      @(negedge clk_i) rst_ni = 1;
      @(negedge clk_i) begin req = 1; id = 5'b10000; we_n = 1; add = 32'h8; end
      #1;
      chk("rs_busy_cleared_gnt", gnt, 1);
      chk("rs_trans_req", trans_req, 1);
      @(negedge clk_i) req = 0;
      #1;
      chk("rs_ar_valid_new", ar_valid, 1);
      chk("rs_no_replay", aw_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
